udp_rx_mp: RTL and testbench



---
 rtl/udp_rx_mp.sv | 245 ++++++++++++++++++++++++
 tb/tb_udp_rx_mp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_mp.sv
// Multi-port GMII UDP receiver: strips preamble/Ethernet/IPv4/UDP headers and streams payload per channel.
// Optional IPv4 header checksum verification when UDP_RX_MP_IP_CSUM_EN is defined.
module udp_rx_mp #(
   parameter logic [47:0] BOARD_MAC    = 48'h00_11_22_33_44_55,
   parameter logic [31:0] BOARD_IP     = {8'd192, 8'd168, 8'd0, 8'd2},
   parameter int          NUM_PORTS    = 4,
   parameter logic [15:0] PORT_BASE    = 16'd1234,
   parameter bit          ACCEPT_BCAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic [7:0]  rec_data,
   output logic        rec_en,
   output logic        rec_sop,
   output logic        rec_eop,
   output logic [1:0]  rec_chan,
   output logic [15:0] rec_byte_num,
   output logic        rec_pkt_done,
   output logic        rec_pkt_err,
   output logic [47:0] src_mac,
   output logic [31:0] src_ip,
   output logic [15:0] src_port,
   output logic [15:0] drop_cnt
);

   typedef enum logic [2:0] {
      IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, RX_DATA, RX_END
   } state_t;

   state_t      state, state_next;
   logic [15:0] cnt;
   logic [39:0] sh;
   logic        hdr_bad;
   logic [3:0]  ihl;
   logic [15:0] ip_len, udp_len, dport, sport, pay_len;
   logic [47:0] mac_tmp;
   logic [31:0] ip_tmp;

   logic [15:0] word16, hdr_len, port_off;
   logic [31:0] word32;
   logic [47:0] word48;
   logic        ip_last, bad_now, drop_inc, port_ok, len_ok, csum_bad;

   assign word16   = {sh[7:0], gmii_rxd};
   assign word32   = {sh[23:0], gmii_rxd};
   assign word48   = {sh[39:0], gmii_rxd};
   assign hdr_len  = {10'd0, ihl, 2'b00};
   assign ip_last  = (cnt == hdr_len - 16'd1);
   assign port_off = dport - PORT_BASE;
   assign port_ok  = (port_off < 16'(NUM_PORTS));
   assign len_ok   = (udp_len >= 16'd8) && (udp_len <= ip_len - hdr_len);

`ifdef UDP_RX_MP_IP_CSUM_EN
   logic [15:0] csum, csum_next;
   logic [16:0] csum_sum;

   // End-around carry folded on every 16-bit word as it completes
   always_comb begin
      csum_sum  = {1'b0, csum} + {1'b0, word16};
      csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};
   end

   always_ff @(posedge clk) begin
      if (state != IP_HDR)
         csum <= '0;
      else if (gmii_rx_dv && cnt[0])
         csum <= csum_next;
   end

   assign csum_bad = (csum_next != 16'hFFFF);
`else
   assign csum_bad = 1'b0;
`endif

   always_comb begin
      state_next = state;
      bad_now    = 1'b0;
      drop_inc   = 1'b0;
      if (!gmii_rx_dv && state != IDLE && state != RX_END) begin
         state_next = IDLE;
         drop_inc   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (gmii_rx_dv && gmii_rxd == 8'h55)
                  state_next = PREAMBLE;
            end
            PREAMBLE: begin
               bad_now = (cnt < 16'd6) ? (gmii_rxd != 8'h55) : (gmii_rxd != 8'hD5);
               if (bad_now) begin
                  state_next = RX_END;
                  drop_inc   = 1'b1;
               end else if (cnt == 16'd6) begin
                  state_next = ETH_HDR;
               end
            end
            ETH_HDR: begin
               if (cnt == 16'd5)
                  bad_now = !((word48 == BOARD_MAC) ||
                              (ACCEPT_BCAST && word48 == 48'hFFFF_FFFF_FFFF));
               if (cnt == 16'd13) begin
                  bad_now = (word16 != 16'h0800);
                  if (hdr_bad || bad_now) begin
                     state_next = RX_END;
                     drop_inc   = 1'b1;
                  end else begin
                     state_next = IP_HDR;
                  end
               end
            end
            IP_HDR: begin
               case (cnt)
                  16'd0:   bad_now = (gmii_rxd[7:4] != 4'd4) || (gmii_rxd[3:0] < 4'd5);
                  16'd7:   bad_now = ((word16 & 16'h3FFF) != 16'd0);
                  16'd9:   bad_now = (gmii_rxd != 8'd17);
                  16'd19:  bad_now = (word32 != BOARD_IP);
                  default: bad_now = 1'b0;
               endcase
               // A bad IHL leaves no header length to wait for, so drop at once
               if (cnt == 16'd0) begin
                  if (bad_now) begin
                     state_next = RX_END;
                     drop_inc   = 1'b1;
                  end
               end else if (ip_last) begin
                  if (hdr_bad || bad_now || csum_bad) begin
                     state_next = RX_END;
                     drop_inc   = 1'b1;
                  end else begin
                     state_next = UDP_HDR;
                  end
               end
            end
            UDP_HDR: begin
               if (cnt == 16'd7) begin
                  if (!port_ok || !len_ok) begin
                     state_next = RX_END;
                     drop_inc   = 1'b1;
                  end else if (udp_len == 16'd8) begin
                     state_next = RX_END;
                  end else begin
                     state_next = RX_DATA;
                  end
               end
            end
            RX_DATA: begin
               if (cnt == pay_len - 16'd1)
                  state_next = RX_END;
            end
            RX_END: begin
               if (!gmii_rx_dv)
                  state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         hdr_bad      <= 1'b0;
         rec_data     <= '0;
         rec_en       <= 1'b0;
         rec_sop      <= 1'b0;
         rec_eop      <= 1'b0;
         rec_chan     <= '0;
         rec_byte_num <= '0;
         rec_pkt_done <= 1'b0;
         rec_pkt_err  <= 1'b0;
         src_mac      <= '0;
         src_ip       <= '0;
         src_port     <= '0;
         drop_cnt     <= '0;
      end else begin
         state        <= state_next;
         cnt          <= (state_next != state) ? 16'd0 : cnt + 16'(gmii_rx_dv);
         hdr_bad      <= (state_next != state) ? 1'b0 : (hdr_bad | bad_now);
         rec_en       <= 1'b0;
         rec_sop      <= 1'b0;
         rec_eop      <= 1'b0;
         rec_pkt_done <= 1'b0;
         rec_pkt_err  <= 1'b0;
         if (drop_inc && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
         if (state == UDP_HDR && cnt == 16'd7 && gmii_rx_dv && !drop_inc) begin
            rec_chan <= port_off[1:0];
            if (state_next == RX_END) begin
               rec_pkt_done <= 1'b1;
               rec_byte_num <= 16'd0;
               src_mac      <= mac_tmp;
               src_ip       <= ip_tmp;
               src_port     <= sport;
            end
         end
         if (state == RX_DATA) begin
            if (gmii_rx_dv) begin
               rec_en   <= 1'b1;
               rec_data <= gmii_rxd;
               if (cnt == 16'd0) begin
                  rec_sop  <= 1'b1;
                  src_mac  <= mac_tmp;
                  src_ip   <= ip_tmp;
                  src_port <= sport;
               end
               if (state_next == RX_END) begin
                  rec_eop      <= 1'b1;
                  rec_pkt_done <= 1'b1;
                  rec_byte_num <= pay_len;
               end
            end else begin
               rec_pkt_err <= 1'b1;
            end
         end
      end
   end

   // Header field capture; values are only consumed after being written in the same frame
   always_ff @(posedge clk) begin
      if (gmii_rx_dv) begin
         sh <= {sh[31:0], gmii_rxd};
         case (state)
            ETH_HDR: begin
               if (cnt == 16'd11) mac_tmp <= word48;
            end
            IP_HDR: begin
               if (cnt == 16'd0)  ihl    <= gmii_rxd[3:0];
               if (cnt == 16'd3)  ip_len <= word16;
               if (cnt == 16'd15) ip_tmp <= word32;
            end
            UDP_HDR: begin
               if (cnt == 16'd1) sport   <= word16;
               if (cnt == 16'd3) dport   <= word16;
               if (cnt == 16'd5) udp_len <= word16;
               if (cnt == 16'd7) pay_len <= udp_len - 16'd8;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_rx_mp.sv
// Directed bench for udp_rx_mp: builds GMII frames byte by byte and checks payload stream, filters and counters.
module tb_udp_rx_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        gmii_rx_dv = 1'b0;
   logic [7:0]  gmii_rxd = 8'h00;

   logic [7:0]  rec_data;
   logic        rec_en, rec_sop, rec_eop, rec_pkt_done, rec_pkt_err;
   logic [1:0]  rec_chan;
   logic [15:0] rec_byte_num, src_port, drop_cnt;
   logic [47:0] src_mac;
   logic [31:0] src_ip;

   logic [7:0]  nb_data;
   logic        nb_en, nb_sop, nb_eop, nb_done, nb_err;
   logic [1:0]  nb_chan;
   logic [15:0] nb_byte_num, nb_src_port, nb_drop_cnt;
   logic [47:0] nb_src_mac;
   logic [31:0] nb_src_ip;

   always #4 clk = ~clk;

   udp_rx_mp dut (
      .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
      .rec_data(rec_data), .rec_en(rec_en), .rec_sop(rec_sop), .rec_eop(rec_eop),
      .rec_chan(rec_chan), .rec_byte_num(rec_byte_num), .rec_pkt_done(rec_pkt_done),
      .rec_pkt_err(rec_pkt_err), .src_mac(src_mac), .src_ip(src_ip),
      .src_port(src_port), .drop_cnt(drop_cnt)
   );

   udp_rx_mp #(.ACCEPT_BCAST(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
      .rec_data(nb_data), .rec_en(nb_en), .rec_sop(nb_sop), .rec_eop(nb_eop),
      .rec_chan(nb_chan), .rec_byte_num(nb_byte_num), .rec_pkt_done(nb_done),
      .rec_pkt_err(nb_err), .src_mac(nb_src_mac), .src_ip(nb_src_ip),
      .src_port(nb_src_port), .drop_cnt(nb_drop_cnt)
   );

   localparam logic [47:0] MY_MAC  = 48'h00_11_22_33_44_55;
   localparam logic [47:0] BC_MAC  = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] SRC_MAC = 48'h02_AA_BB_CC_DD_EE;
   localparam logic [31:0] MY_IP   = 32'hC0A8_0002;
   localparam logic [31:0] SRC_IP  = 32'hC0A8_0064;

   int tests = 0;
   int fails = 0;

   logic [7:0] fq[$];
   logic [7:0] pay[128];
   int         pay_start;

   int         cap_n, sop_n, eop_n, done_n, err_n, nb_en_n;
   logic [7:0] cap[256];
   logic [7:0] sop_data, eop_data;
   logic [15:0] done_bn;
   logic [1:0]  done_chan;

   always @(negedge clk) begin
      if (rec_en) begin
         if (cap_n < 256) cap[cap_n] = rec_data;
         cap_n++;
         if (rec_sop) begin sop_n++; sop_data = rec_data; end
         if (rec_eop) begin eop_n++; eop_data = rec_data; end
      end
      if (rec_pkt_done) begin done_n++; done_bn = rec_byte_num; done_chan = rec_chan; end
      if (rec_pkt_err) err_n++;
      if (nb_en) nb_en_n++;
   end

   task automatic clear_mon();
      cap_n = 0; sop_n = 0; eop_n = 0; done_n = 0; err_n = 0; nb_en_n = 0;
      sop_data = 8'h00; eop_data = 8'h00; done_bn = 16'hFFFF; done_chan = 2'd3;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic build(input logic [47:0] dmac, input int ihl, input logic [7:0] proto,
                        input bit mf, input logic [31:0] dip, input logic [15:0] dport,
                        input int plen, input bit csum_bad);
      logic [7:0]  h[64];
      logic [15:0] tot, ulen, ck;
      logic [47:0] smac;
      int unsigned s;
      int hl, eth_len;
      hl   = ihl * 4;
      tot  = 16'(hl + 8 + plen);
      ulen = 16'(8 + plen);
      smac = SRC_MAC;
      for (int i = 0; i < 64; i++) h[i] = 8'h01;
      h[0] = {4'd4, 4'(ihl)}; h[1] = 8'h00; h[2] = tot[15:8]; h[3] = tot[7:0];
      h[4] = 8'h00; h[5] = 8'h01; h[6] = mf ? 8'h20 : 8'h40; h[7] = 8'h00;
      h[8] = 8'd64; h[9] = proto; h[10] = 8'h00; h[11] = 8'h00;
      h[12] = 8'hC0; h[13] = 8'hA8; h[14] = 8'h00; h[15] = 8'h64;
      h[16] = dip[31:24]; h[17] = dip[23:16]; h[18] = dip[15:8]; h[19] = dip[7:0];
      s = 0;
      for (int i = 0; i < hl; i += 2) s += {16'd0, h[i], h[i+1]};
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      ck = ~s[15:0];
      h[10] = ck[15:8];
      h[11] = ck[7:0] ^ (csum_bad ? 8'h01 : 8'h00);
      fq.delete();
      repeat (7) fq.push_back(8'h55);
      fq.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) fq.push_back(dmac[8*i +: 8]);
      for (int i = 5; i >= 0; i--) fq.push_back(smac[8*i +: 8]);
      fq.push_back(8'h08); fq.push_back(8'h00);
      for (int i = 0; i < hl; i++) fq.push_back(h[i]);
      fq.push_back(8'h13); fq.push_back(8'h88);
      fq.push_back(dport[15:8]); fq.push_back(dport[7:0]);
      fq.push_back(ulen[15:8]); fq.push_back(ulen[7:0]);
      fq.push_back(8'h00); fq.push_back(8'h00);
      pay_start = fq.size();
      for (int i = 0; i < plen; i++) fq.push_back(pay[i % 128]);
      eth_len = 14 + hl + 8 + plen;
      while (eth_len < 60) begin fq.push_back(8'h00); eth_len++; end
      fq.push_back(8'h12); fq.push_back(8'h34); fq.push_back(8'h56); fq.push_back(8'h78);
   endtask

   task automatic send(input int trunc, input int gap);
      int n;
      n = (trunc < 0) ? fq.size() : pay_start + trunc;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         gmii_rx_dv = 1'b1; gmii_rxd = fq[i];
      end
      for (int i = 0; i < gap; i++) begin
         @(posedge clk); #1;
         gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
      end
   endtask

   initial begin
      int bad;
      for (int i = 0; i < 128; i++) pay[i] = 8'(i);
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("reset_src_ip", 64'(src_ip), 64'd0);
      chk("reset_done", 64'(rec_pkt_done), 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Broadcast destination: accepted by default instance, refused without ACCEPT_BCAST
      clear_mon();
      build(BC_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1235, 4, 1'b0);
      send(-1, 12);
      chk("bcast_done", 64'(done_n), 64'd1);
      chk("bcast_drop", 64'(drop_cnt), 64'd0);
      chk("nobcast_en", 64'(nb_en_n), 64'd0);
      chk("nobcast_drop", 64'(nb_drop_cnt), 64'd1);

      // Unicast frame, 18-byte payload on port 1235
      clear_mon();
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1235, 18, 1'b0);
      send(-1, 12);
      chk("t1_en_cnt", 64'(cap_n), 64'd18);
      bad = 0;
      for (int i = 0; i < 18; i++) if (cap[i] !== 8'(i)) bad++;
      chk("t1_bytes_bad", 64'(bad), 64'd0);
      chk("t1_sop", 64'({sop_n[7:0], sop_data}), 64'h0100);
      chk("t1_eop", 64'({eop_n[7:0], eop_data}), 64'h0111);
      chk("t1_done", 64'(done_n), 64'd1);
      chk("t1_byte_num", 64'(done_bn), 64'd18);
      chk("t1_chan", 64'(done_chan), 64'd1);
      chk("t1_src_mac", 64'(src_mac), 64'(SRC_MAC));
      chk("t1_src_ip", 64'(src_ip), 64'(SRC_IP));
      chk("t1_src_port", 64'(src_port), 64'd5000);

      // IHL=6 with options, port 1234, payload DE AD BE EF
      clear_mon();
      pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
      build(MY_MAC, 6, 8'd17, 1'b0, MY_IP, 16'd1234, 4, 1'b0);
      send(-1, 12);
      for (int i = 0; i < 4; i++) pay[i] = 8'(i);
      chk("opt_en_cnt", 64'(cap_n), 64'd4);
      chk("opt_bytes", 64'({cap[0], cap[1], cap[2], cap[3]}), 64'hDEADBEEF);
      chk("opt_chan", 64'(done_chan), 64'd0);
      chk("opt_byte_num", 64'(done_bn), 64'd4);

      // Filter drops, one per frame
      clear_mon();
      build(MY_MAC, 5, 8'd17, 1'b0, 32'hC0A8_0003, 16'd1235, 8, 1'b0);
      send(-1, 12);
      chk("drop_ip", 64'(drop_cnt), 64'd1);
      build(MY_MAC, 5, 8'd6, 1'b0, MY_IP, 16'd1235, 8, 1'b0);
      send(-1, 12);
      chk("drop_proto", 64'(drop_cnt), 64'd2);
      build(MY_MAC, 5, 8'd17, 1'b1, MY_IP, 16'd1235, 8, 1'b0);
      send(-1, 12);
      chk("drop_mf", 64'(drop_cnt), 64'd3);
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1238, 8, 1'b0);
      send(-1, 12);
      chk("drop_port", 64'(drop_cnt), 64'd4);
      chk("drop_no_en", 64'(cap_n + done_n), 64'd0);

      // Truncated payload: 10 of 100 bytes
      clear_mon();
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1236, 100, 1'b0);
      send(10, 12);
      chk("trunc_en_cnt", 64'(cap_n), 64'd10);
      chk("trunc_err", 64'(err_n), 64'd1);
      chk("trunc_no_done", 64'(done_n), 64'd0);
      chk("trunc_drop", 64'(drop_cnt), 64'd5);

      clear_mon();
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1237, 18, 1'b0);
      send(-1, 12);
      chk("after_trunc_done", 64'(done_n), 64'd1);
      chk("after_trunc_bn", 64'(done_bn), 64'd18);
      chk("after_trunc_chan", 64'(done_chan), 64'd3);

      // Zero-length payload
      clear_mon();
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1235, 0, 1'b0);
      send(-1, 12);
      chk("zero_done", 64'(done_n), 64'd1);
      chk("zero_bn", 64'(done_bn), 64'd0);
      chk("zero_no_en", 64'(cap_n), 64'd0);
      chk("zero_drop", 64'(drop_cnt), 64'd5);

      // Back-to-back frames with a single idle cycle
      clear_mon();
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1235, 6, 1'b0);
      send(-1, 1);
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1234, 7, 1'b0);
      send(-1, 12);
      chk("b2b_done", 64'(done_n), 64'd2);
      chk("b2b_en_cnt", 64'(cap_n), 64'd13);

`ifdef UDP_RX_MP_IP_CSUM_EN
      clear_mon();
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1235, 8, 1'b1);
      send(-1, 12);
      chk("csum_bad_drop", 64'(drop_cnt), 64'd6);
      chk("csum_bad_no_en", 64'(cap_n), 64'd0);
      build(MY_MAC, 6, 8'd17, 1'b0, MY_IP, 16'd1235, 8, 1'b0);
      send(-1, 12);
      chk("csum_ok_done", 64'(done_n), 64'd1);
`endif

      // Asynchronous reset in the middle of a payload
      build(MY_MAC, 5, 8'd17, 1'b0, MY_IP, 16'd1235, 18, 1'b0);
      send(5, 0);
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1; gmii_rxd = fq[pay_start + 5];
      chk("midrst_pre_en", 64'(rec_en), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_en", 64'(rec_en), 64'd0);
      chk("midrst_data", 64'(rec_data), 64'd0);
      chk("midrst_drop", 64'(drop_cnt), 64'd0);
      chk("midrst_src_mac", 64'(src_mac), 64'd0);
      gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
      #10 rst = 1'b0;
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
